// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and byte-lane helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Undefined codes (011, 110, 111) fall through to word.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// MEM-stage request / response bundle between the pipeline and the LSU.
interface dmem_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  stall;
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  misaligned;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  stall, rdata_valid, rdata, misaligned
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output stall, rdata_valid, rdata, misaligned
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension from an aligned 32-bit RAM word.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0, lane_h};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit with an internal byte-addressable RAM and
// WAIT_STATES wait cycles.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [7:0] ram [DEPTH];

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  req_we_q, req_we_d;
    logic [2:0]            req_funct3_q, req_funct3_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  misaligned_q, misaligned_d;

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_we;
    logic [2:0]            acc_funct3;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [ADDR_WIDTH-3:0] acc_base;
    logic                  acc_mis;
    logic [3:0]            acc_be;
    logic                  ram_we;
    logic [31:0]           ram_word;
    logic [31:0]           wlanes;
    logic [31:0]           load_data;
    logic                  addr_hi_unused;

    assign addr_hi_unused = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    always_comb begin
        accept       = bus.req_valid && (state_q != S_WAIT);
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_we_d     = req_we_q;
        req_funct3_d = req_funct3_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (accept) begin
                    req_we_d     = bus.req_we;
                    req_funct3_d = bus.req_funct3;
                    req_addr_d   = bus.req_addr[ADDR_WIDTH-1:0];
                    req_wdata_d  = bus.req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // The access is performed on the edge that enters RESP, so the
        // registered result is visible throughout the RESP cycle. With zero
        // wait states that edge is the acceptance edge, hence the live bus.
        enter_resp = (state_d == S_RESP);
        if (state_q == S_WAIT) begin
            acc_we     = req_we_q;
            acc_funct3 = req_funct3_q;
            acc_addr   = req_addr_q;
            acc_wdata  = req_wdata_q;
        end else begin
            acc_we     = bus.req_we;
            acc_funct3 = bus.req_funct3;
            acc_addr   = bus.req_addr[ADDR_WIDTH-1:0];
            acc_wdata  = bus.req_wdata;
        end

        acc_base = acc_addr[ADDR_WIDTH-1:2];
        acc_mis  = is_misaligned(acc_funct3, acc_addr[1:0]);
        acc_be   = byte_en(acc_funct3, acc_addr[1:0]);
        ram_we   = enter_resp && acc_we && !acc_mis;
        ram_word = {ram[{acc_base, 2'd3}], ram[{acc_base, 2'd2}],
                    ram[{acc_base, 2'd1}], ram[{acc_base, 2'd0}]};

        case (access_size(acc_funct3))
            SZ_BYTE: wlanes = {4{acc_wdata[7:0]}};
            SZ_HALF: wlanes = {2{acc_wdata[15:0]}};
            default: wlanes = acc_wdata[31:0];
        endcase

        rdata_valid_d = enter_resp;
        misaligned_d  = enter_resp && acc_mis;
        rdata_d       = rdata_q;
        if (enter_resp) begin
            rdata_d = (acc_we || acc_mis) ? '0 : load_data;
        end
    end

    dmem_load_ext u_load_ext (
        .word    (ram_word),
        .addr_lo (acc_addr[1:0]),
        .funct3  (acc_funct3),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 3'd0;
            req_we_q      <= 1'b0;
            req_funct3_q  <= 3'd0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_we_q      <= req_we_d;
            req_funct3_q  <= req_funct3_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // RAM has no reset; a reset edge only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            if (acc_be[0]) ram[{acc_base, 2'd0}] <= wlanes[7:0];
            if (acc_be[1]) ram[{acc_base, 2'd1}] <= wlanes[15:8];
            if (acc_be[2]) ram[{acc_base, 2'd2}] <= wlanes[23:16];
            if (acc_be[3]) ram[{acc_base, 2'd3}] <= wlanes[31:24];
        end
    end

    assign bus.stall       = !rst && ((state_q == S_WAIT) ||
                             (bus.req_valid && (state_q == S_IDLE || state_q == S_RESP)));
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.misaligned  = misaligned_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, wrap/reset/back-to-back sequences
// and randomized traffic against a byte-array reference model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel0 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_lsu_if #(.DATA_WIDTH(32)) bus1 ();
    dmem_lsu_if #(.DATA_WIDTH(32)) bus0 ();

    assign bus1.req_valid  = req_valid && !sel0;
    assign bus0.req_valid  = req_valid && sel0;
    assign bus1.req_we     = req_we;
    assign bus0.req_we     = req_we;
    assign bus1.req_funct3 = req_funct3;
    assign bus0.req_funct3 = req_funct3;
    assign bus1.req_addr   = req_addr;
    assign bus0.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus0.req_wdata  = req_wdata;

    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    logic        stall_m, valid_m, mis_m;
    logic [31:0] rdata_m;
    assign stall_m = sel0 ? bus0.stall       : bus1.stall;
    assign valid_m = sel0 ? bus0.rdata_valid : bus1.rdata_valid;
    assign mis_m   = sel0 ? bus0.misaligned  : bus1.misaligned;
    assign rdata_m = sel0 ? bus0.rdata       : bus1.rdata;

    // Reference memory: index 1 mirrors the WAIT_STATES=1 unit, 0 the other.
    logic [7:0] model_mem [2][4096];

    function automatic int model_width(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % model_width(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] addr);
        int w;
        int a;
        logic [31:0] v;
        w = model_width(f3);
        a = int'(addr & 32'hFFF);
        v = 32'd0;
        for (int i = 0; i < w; i++) v = v | (32'(model_mem[d][a + i]) << (8 * i));
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * w - 1]) v = v | (32'hFFFF_FFFF << (8 * w));
        return v;
    endfunction

    task automatic model_store(input int d, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int w;
        int a;
        w = model_width(f3);
        a = int'(addr & 32'hFFF);
        for (int i = 0; i < w; i++) model_mem[d][a + i] = 8'(wd >> (8 * i));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One isolated transaction; returns the response plus latency and the
    // number of cycles stall was seen high (acceptance cycle through response).
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                         output int lat, output int stalls);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        stalls = stall_m ? 1 : 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rd = 32'd0;
        mis = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (stall_m) stalls++;
        end while (!valid_m && lat < 20);
        if (valid_m) begin
            rd  = rdata_m;
            mis = mis_m;
        end else begin
            checks++;
            failures++;
            $display("FAIL op_timeout actual=no_rdata_valid expected=rdata_valid addr=%h", addr);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];
    logic [2:0] st_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;
        int          stalls;
        logic [31:0] bb_data [3];

        vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF12, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_12EF, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0000, 32'h0102_0304, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0003, 32'h0000_AAAA, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_1010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'hABCD_1013, 32'h0,         32'hFFFF_FFCA, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0});

        // Reset state of both units.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel0 = (d == 0);
            #1;
            chk("reset_stall",       32'(stall_m), 32'd0);
            chk("reset_rdata_valid", 32'(valid_m), 32'd0);
            chk("reset_rdata",       rdata_m,      32'd0);
            chk("reset_misaligned",  32'(mis_m),   32'd0);
        end
        sel0 = 1'b0;

        // Directed table on the one-wait-state unit.
        foreach (vecs[i]) begin
            do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, mis, lat, stalls);
            chk($sformatf("vec%0d_rdata", i),   rd,          vecs[i].exp_rdata);
            chk($sformatf("vec%0d_mis", i),     32'(mis),    32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_latency", i), 32'(lat),    32'd2);
            chk($sformatf("vec%0d_stalls", i),  32'(stalls), 32'd2);
        end

        // Reset during the wait cycle of a store must drop the store.
        do_op(1'b1, 3'b010, 32'h020, 32'h0, rd, mis, lat, stalls);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h020; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall",       32'(stall_m), 32'd0);
        chk("rst_mid_rdata_valid", 32'(valid_m), 32'd0);
        do_op(1'b0, 3'b010, 32'h020, 32'h0, rd, mis, lat, stalls);
        chk("rst_mid_store_dropped", rd, 32'h0);

        // Back-to-back loads on the zero-wait-state unit.
        sel0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bb_data[i] = $urandom;
            do_op(1'b1, 3'b010, 32'h040 + 32'(4 * i), bb_data[i], rd, mis, lat, stalls);
            chk("ws0_store_latency", 32'(lat),    32'd1);
            chk("ws0_store_stalls",  32'(stalls), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h040;
        #1 chk("b2b_stall_first", 32'(stall_m), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) req_addr = 32'h040 + 32'(4 * (i + 1));
            else req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b%0d_valid", i), 32'(valid_m), 32'd1);
            chk($sformatf("b2b%0d_rdata", i), rdata_m,      bb_data[i]);
            chk($sformatf("b2b%0d_stall", i), 32'(stall_m), (i < 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("b2b_valid_drops", 32'(valid_m), 32'd0);

        // Randomized traffic in a 64-byte window, upper address bits random.
        for (int d = 1; d >= 0; d--) begin
            sel0 = (d == 0);
            for (int k = 0; k < 16; k++) begin
                logic [31:0] wd;
                wd = $urandom;
                do_op(1'b1, 3'b010, 32'h100 + 32'(4 * k), wd, rd, mis, lat, stalls);
                model_store(d, 3'b010, 32'h100 + 32'(4 * k), wd);
            end
            for (int n = 0; n < 150; n++) begin
                logic        we;
                logic [2:0]  f3;
                logic [31:0] addr;
                logic [31:0] wd;
                logic [31:0] exp_rd;
                logic        exp_mis;
                we   = 1'($urandom_range(0, 1));
                f3   = we ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
                addr = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
                wd   = $urandom;
                exp_mis = model_mis(f3, addr);
                exp_rd  = (!we && !exp_mis) ? model_load(d, f3, addr) : 32'h0;
                if (we && !exp_mis) model_store(d, f3, addr, wd);
                do_op(we, f3, addr, wd, rd, mis, lat, stalls);
                chk($sformatf("rnd_d%0d_n%0d_rdata", d, n),   rd,          exp_rd);
                chk($sformatf("rnd_d%0d_n%0d_mis", d, n),     32'(mis),    32'(exp_mis));
                chk($sformatf("rnd_d%0d_n%0d_latency", d, n), 32'(lat),    32'(d + 1));
                chk($sformatf("rnd_d%0d_n%0d_stalls", d, n),  32'(stalls), 32'(d + 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit and data memory responder for the MEM stage of the pipelined RV32I core.
- Accepts one load/store request from the MEM stage, performs a byte/half/word access to an internal byte-addressable RAM after a configurable number of wait states, and returns aligned, sign/zero-extended load data.
- Load data feeds the writeback result select as ReadDataW. A stall output freezes the pipeline while an access is in flight.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for RV32.
- ADDR_WIDTH, 12, byte-address bits used; RAM depth is 2**ADDR_WIDTH bytes.
- WAIT_STATES, 1, extra cycles between acceptance and response; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage presents a memory op.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  DATA_WIDTH  byte address; only low ADDR_WIDTH bits used.
- req_wdata  in  DATA_WIDTH  store data; low byte/half used for SB/SH.
- stall  out  1  hold the pipeline.
- rdata_valid  out  1  one-cycle response pulse (loads and stores).
- rdata  out  DATA_WIDTH  extended load data; 0 for stores and misaligned ops.
- misaligned  out  1  qualifies rdata_valid: the access was misaligned and suppressed.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high, using ports clk and rst.
- FSM states and transitions:
  - IDLE: if req_valid, latch the request. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: a 3-bit counter loads WAIT_STATES-1 on acceptance and decrements each cycle. At 0, go to RESP.
  - RESP: the RAM access happens here. rdata_valid=1 for exactly this cycle. If req_valid is high this cycle, the new request is accepted back-to-back (same transitions as IDLE); otherwise go to IDLE.
- stall = (state==WAIT) or (req_valid and state in {IDLE, RESP}). stall is 0 in the RESP cycle unless a new request is accepted in that cycle.
- Latency: rdata_valid asserts exactly WAIT_STATES+1 cycles after the acceptance edge.
- Loads:
  - Read the 4-byte lane group at {addr[ADDR_WIDTH-1:2], 2'b00} and select the byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata is registered and valid only while rdata_valid=1; it holds its last value otherwise.
- Stores:
  - Byte enables derive from funct3 and addr[1:0]; write commits on the RESP clock edge.
  - A load in the next transaction observes the stored data (no read-during-write hazard, since accesses are serialized).
- Misalignment:
  - Defined as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Behaviour: no RAM read or write, rdata=0, misaligned=1 with rdata_valid.
- Address: bits above ADDR_WIDTH are ignored, so addresses wrap modulo the RAM size.
- Undefined funct3 (011, 110, 111): treated as LW/SW.
- Reset:
  - state=IDLE, counter=0, stall=0, rdata_valid=0, rdata=0, misaligned=0.
  - Reset mid-access aborts the access; a pending store is not written.
  - RAM contents are not affected by reset.
- req_* inputs are ignored in WAIT; the latched copy is used.

Optional Feature:
- Macro: DMEM_PRELOAD_EN.
- Defined: the RAM is initialised at elaboration via $readmemh from the file "dmem_init.hex" (byte per line, from address 0).
- Undefined: no initial block; unwritten locations read as X in simulation.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - FSM typedef enum {S_IDLE, S_WAIT, S_RESP}.
  - Function computing the 4-bit byte-enable from funct3 and addr[1:0].
- Sub-module dmem_load_ext: combinational lane select plus sign/zero extension from the 32-bit word, addr[1:0] and funct3.

Test Plan:
- Reset then SW 0xDEADBEEF @0x010, then LW @0x010 (WAIT_STATES=1): stall high 2 cycles per op, rdata_valid 2 cycles after acceptance, rdata=0xDEADBEEF.
- After the above, LB @0x010 -> 0xFFFFFFEF; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x010 -> 0x0000BEEF.
- SB 0x12 @0x011, then LW @0x010 -> 0xDEAD12EF (only byte 1 modified).
- LW @0x011 and SH @0x003 -> misaligned=1, rdata=0, and a following LW @0x000 shows the memory unchanged.
- Back-to-back: req_valid held high for 3 loads with WAIT_STATES=0 -> three consecutive rdata_valid pulses; stall=1 on each request cycle. SW @0x1010 with ADDR_WIDTH=12 then LW @0x010 -> stored value returned (wrap).
- Assert rst during WAIT of SW 0x55 @0x020 -> next cycle stall=0, rdata_valid=0; subsequent LW @0x020 does not return 0x55.
